// File: rtl/tfout.sv
// rtl/tfout.sv - byte-serialising output table: captures a packed record, emits it oldest byte first
//
// Purpose: holds up to 16 bytes loaded in parallel and hands them out one per
// rd handshake, oldest (byte len-1) first, newest (byte 0) last.
// Optional feature: define TFOUT_PARITY_EN to add the parity output.
//
// Ports:
//   clk       in   1    sole clock, rising edge
//   rst_n     in   1    asynchronous active-low reset
//   a         in   128  packed record, byte k = a[8k+7:8k]
//   len       in   5    valid byte count of a (values >= 16 mean 16)
//   load      in   1    capture a/len this cycle
//   clr       in   1    synchronous abort, also clears ovf
//   rd        in   1    consumer takes dataout this cycle
//   dataout   out  8    oldest unsent byte (0 when empty)
//   valid     out  1    dataout holds a real byte
//   countout  out  5    bytes remaining, including dataout
//   tbneout   out  1    table not empty
//   ovf       out  1    sticky: a load arrived while busy and was rejected
//   parity    out  1    XOR of dataout, 0 when idle (TFOUT_PARITY_EN only)

module tfout (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] a,
  input  logic [4:0]   len,
  input  logic         load,
  input  logic         clr,
  input  logic         rd,
  output logic [7:0]   dataout,
  output logic         valid,
  output logic [4:0]   countout,
  output logic         tbneout,
  output logic         ovf
`ifdef TFOUT_PARITY_EN
  ,
  output logic         parity
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    BUSY  = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [127:0]   shifter_q, shifter_d;
  logic [4:0]     count_q, count_d;
  logic           ovf_q, ovf_d;

  logic [4:0]     len_eff;
  logic [7:0]     shift_amt;
  logic           handshake;
  logic           load_req;
  logic           last_taken;
  logic           accept;

  // Lengths above 16 saturate; the record is left-justified so its oldest
  // byte lands in the top byte lane that drives dataout.
  assign len_eff    = (len >= 5'd16) ? 5'd16 : len;
  assign shift_amt  = {(5'd16 - len_eff), 3'b000};

  assign handshake  = (state_q == BUSY) && rd;
  assign load_req   = load && (len != 5'd0);
  // The final byte leaving this cycle frees the table in time for a new record.
  assign last_taken = handshake && (count_q == 5'd1);
  assign accept     = load_req && ((state_q == EMPTY) || last_taken);

  always_comb begin
    state_d   = state_q;
    shifter_d = shifter_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    if (clr) begin
      state_d   = EMPTY;
      shifter_d = '0;
      count_d   = '0;
      ovf_d     = 1'b0;
    end else begin
      if (accept) begin
        state_d   = BUSY;
        shifter_d = a << shift_amt;
        count_d   = len_eff;
      end else if (handshake) begin
        shifter_d = {shifter_q[119:0], 8'h00};
        count_d   = count_q - 5'd1;
        if (count_q == 5'd1) begin
          state_d = EMPTY;
        end
      end
      if (load_req && !accept) begin
        // Only reachable while BUSY: an EMPTY table always accepts.
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      shifter_q <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shifter_q <= shifter_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  // All outputs come straight from flops, so rd never reaches dataout.
  assign dataout  = shifter_q[127:120];
  assign valid    = (state_q == BUSY);
  assign countout = count_q;
  assign tbneout  = (count_q != 5'd0);
  assign ovf      = ovf_q;

`ifdef TFOUT_PARITY_EN
  assign parity = valid & (^shifter_q[127:120]);
`endif

endmodule
